// File: rtl/hex_digest_pager.sv
// Pages a captured digest onto four hex digits, one WIN_W-bit window per page.
// Pages advance on a synchronized button edge or an auto-scroll dwell timer.
module hex_digest_pager #(
   parameter  int DIGEST_W = 256,
   parameter  int WIN_W    = 16,
   parameter  int DWELL    = 50000000,
   localparam int PAGES    = DIGEST_W / WIN_W,
   localparam int PW       = $clog2(PAGES)
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [DIGEST_W-1:0] digest,
   input  logic                digest_valid,
   input  logic                clear,
   input  logic                btn_next,
   input  logic                auto_en,
   output logic [3:0]          HEX0,
   output logic [3:0]          HEX1,
   output logic [3:0]          HEX2,
   output logic [3:0]          HEX3,
   output logic                blank,
   output logic [PW-1:0]       page,
   output logic                auto_mode
);

   localparam int CW = $clog2(DWELL);

   typedef enum logic [1:0] {IDLE, MANUAL, AUTO} state_t;

   state_t                state_reg, state_next;
   logic [DIGEST_W-1:0]   digest_reg, digest_next;
   logic [PW-1:0]         page_reg, page_next;
   logic [CW-1:0]         cnt_reg, cnt_next;
   logic                  s1_reg, s2_reg, s3_reg;
   logic                  adv;
   logic                  dwell_done;
   logic [PW-1:0]         page_inc;
   logic [WIN_W-1:0]      win [PAGES];
   logic [WIN_W-1:0]      window;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg  <= IDLE;
         digest_reg <= '0;
         page_reg   <= '0;
         cnt_reg    <= '0;
         s1_reg     <= 1'b0;
         s2_reg     <= 1'b0;
         s3_reg     <= 1'b0;
      end else begin
         state_reg  <= state_next;
         digest_reg <= digest_next;
         page_reg   <= page_next;
         cnt_reg    <= cnt_next;
         s1_reg     <= btn_next;
         s2_reg     <= s1_reg;
         s3_reg     <= s2_reg;
      end
   end

   // One-cycle pulse on the synchronized rising edge; a held button advances once.
   assign adv        = s2_reg & ~s3_reg;
   assign dwell_done = (cnt_reg == CW'(DWELL - 1));
   assign page_inc   = (page_reg == PW'(PAGES - 1)) ? '0 : page_reg + 1'b1;

   always_comb begin
      state_next  = state_reg;
      digest_next = digest_reg;
      page_next   = page_reg;
      cnt_next    = cnt_reg;
      if (clear) begin
         state_next = IDLE;
         page_next  = '0;
         cnt_next   = '0;
      end else if (digest_valid) begin
         digest_next = digest;
         page_next   = '0;
         cnt_next    = '0;
         state_next  = auto_en ? AUTO : MANUAL;
      end else begin
         case (state_reg)
            MANUAL: begin
               if (adv) page_next = page_inc;
               if (auto_en) begin
                  state_next = AUTO;
                  cnt_next   = '0;
               end
            end
            AUTO: begin
               // Leaving auto-scroll freezes the page where it is.
               if (!auto_en) begin
                  state_next = MANUAL;
                  cnt_next   = '0;
               end else if (adv || dwell_done) begin
                  page_next = page_inc;
                  cnt_next  = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Page 0 is the most-significant window of the digest.
   generate
      for (genvar gi = 0; gi < PAGES; gi++) begin : g_win
         assign win[gi] = digest_reg[DIGEST_W-1-gi*WIN_W -: WIN_W];
      end
   endgenerate

   assign window    = win[page_reg];
   assign blank     = (state_reg == IDLE);
   assign auto_mode = (state_reg == AUTO);
   assign page      = page_reg;
   assign HEX0      = blank ? 4'h0 : window[3:0];
   assign HEX1      = blank ? 4'h0 : window[7:4];
   assign HEX2      = blank ? 4'h0 : window[11:8];
   assign HEX3      = blank ? 4'h0 : window[15:12];

endmodule

// File: doc/hex_digest_pager.md
Name: hex_digest_pager

Overview:
Display sequencer that pages a captured SHA-256 digest onto the four-digit seven-segment bank, one 16-bit window at a time. It drives the four nibble inputs of the per-digit HexDriver instances. Pages advance either on a debounced-by-synchronizer push button or on an auto-scroll dwell timer. Sits between the hash core's digest output and the board display logic.

Parameters:
DIGEST_W, 256, digest width in bits; must be a multiple of WIN_W.
WIN_W, 16, window width shown at once (four hex digits).
DWELL, 50000000, auto-scroll period in clock cycles; must be >= 2.
PAGES (derived), DIGEST_W/WIN_W = 16, number of windows.
PW (derived), $clog2(PAGES) = 4, page index width.

Ports:
Clk  in  1  system clock; all state updates on the rising edge.
Reset  in  1  asynchronous, active-high reset.
digest  in  DIGEST_W  digest from hash core; sampled only when digest_valid=1.
digest_valid  in  1  single-cycle strobe: capture digest, restart at page 0.
clear  in  1  synchronous level; return to IDLE and blank the display.
btn_next  in  1  raw asynchronous push-button, active-high; advance one page.
auto_en  in  1  level; 1 = auto-scroll, 0 = manual paging.
HEX0  out  4  least-significant nibble of the current window.
HEX1  out  4  nibble 1 of the window.
HEX2  out  4  nibble 2 of the window.
HEX3  out  4  most-significant nibble of the window.
blank  out  1  1 = no valid digest; board logic forces segments off.
page  out  PW  current page index.
auto_mode  out  1  1 while in state AUTO.

Behaviour:
- Reset (async, any time, including mid-scroll): state=IDLE, digest register=0, page=0, dwell counter=0, sync flops=0. Outputs: HEX0-3=0, blank=1, page=0, auto_mode=0.
- States: IDLE, MANUAL, AUTO. All outputs are registered or decoded directly from registered state.
- IDLE: blank=1, HEX0-3=0, btn_next and auto_en are ignored. A digest_valid=1 sample captures digest, sets page=0 and clears the dwell counter. Next state is AUTO if auto_en=1, otherwise MANUAL.
- Window mapping: page p selects digest_reg[DIGEST_W-1-p*WIN_W -: WIN_W].
  - Page 0 is the top 16 bits.
  - HEX3 = window[15:12], HEX0 = window[3:0].
  - blank=0 in MANUAL and AUTO.
- Button path: btn_next passes through 2 flops (s1, s2) plus a delay flop s3. Advance pulse = s2 & ~s3. When btn_next first goes high before edge k, the page changes at edge k+2. A held button produces exactly one advance.
- MANUAL: an advance pulse sets page = page+1, wrapping 15 -> 0. If auto_en=1, the next state is AUTO and the dwell counter is cleared.
- AUTO:
  - The dwell counter counts 0..DWELL-1.
  - At DWELL-1 it advances the page (wrapping) and clears the counter, so the page period is exactly DWELL cycles from AUTO entry.
  - An advance pulse also steps the page and clears the counter.
  - If auto_en=0, the next state is MANUAL, the page is held and the counter is cleared.
- Digest_valid in MANUAL/AUTO: recapture the digest, set page=0, clear the counter; mode follows auto_en.
- Same-cycle priority, highest first: Reset > clear > digest_valid > advance pulse > dwell expiry. A dwell expiry coinciding with an advance pulse yields a single +1.
- clear from any state: next state IDLE, page=0, counter=0. The digest register is kept but not displayed.
- Latency: a digest_valid or clear sampled at edge k is reflected on the outputs after edge k.

Test Plan:
1. Reset, then digest_valid with digest[255:240]=16'hBA78 and auto_en=0. Expect after the next edge: HEX3..HEX0 = B,A,7,8; page=0; blank=0; auto_mode=0.
2. In MANUAL, pulse btn_next high for 10 cycles. Expect page 0->1 exactly 2 edges after the first high sample, with a single increment. Repeat 16 presses: page wraps 15->0 and the HEX outputs match digest slices each step.
3. DWELL=4, auto_en=1 on capture. Expect page = 1, 2, 3 at 4, 8, 12 cycles after AUTO entry. Drop auto_en: expect MANUAL with the page held.
4. In AUTO, make the advance pulse coincide with dwell expiry. Expect page +1 only and the counter restarted.
5. Assert clear and digest_valid in the same cycle. Expect IDLE, blank=1, HEX=0. Then digest_valid alone: expect the new digest shown at page 0.
6. Assert Reset asynchronously mid-AUTO at page 7. Expect blank=1, page=0, auto_mode=0 immediately, without waiting for a clock edge.
